dma_stream_writer: RTL and testbench

- Upstream neighbour of the buffer controller.
- Takes one transfer descriptor at a time: destination address, beat count and address stride.
- Consumes a 32-bit input data stream through a small FIFO and issues address-incrementing DMA write beats into the buffer address map with a valid/ready handshake.
- Reports busy, done and error status to the control CSRs.

---
 rtl/dma_stream_writer_pkg.sv | 33 +++
 rtl/dma_stream_writer_if.sv | 44 ++++
 rtl/dma_sync_fifo.sv | 57 +++++
 rtl/dma_stream_writer.sv | 174 +++++++++++++++++
 tb/tb_dma_stream_writer.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_stream_writer_pkg.sv
// garuda_dma_pkg: shared types and constants for the DMA stream writer.
//   - dma_state_e : writer FSM states
//   - dma_desc_t  : transfer descriptor (dst, len, stride)
//   - REGION_BASE/REGION_LIMIT : buffer address map regions, also used by
//     the buffer controller decode (index 0 weight, 1 act ping, 2 act pong,
//     3 acc)
package garuda_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_ABORT,
    S_DONE,
    S_ERR
  } dma_state_e;

  localparam int DMA_ADDR_W   = 32;
  localparam int DMA_LEN_W    = 16;
  localparam int DMA_STRIDE_W = 16;

  typedef struct packed {
    logic [DMA_ADDR_W-1:0]   dst;
    logic [DMA_LEN_W-1:0]    len;
    logic [DMA_STRIDE_W-1:0] stride;
  } dma_desc_t;

  localparam int NUM_REGIONS = 4;
  localparam logic [NUM_REGIONS-1:0][31:0] REGION_BASE =
    {32'h0004_0000, 32'h0003_0000, 32'h0002_0000, 32'h0000_0000};
  localparam logic [NUM_REGIONS-1:0][31:0] REGION_LIMIT =
    {32'h0004_7FFF, 32'h0003_FFFF, 32'h0002_FFFF, 32'h0001_FFFF};

endpackage

// File: rtl/dma_stream_writer_if.sv
// dma_stream_writer_if: descriptor, source-stream and DMA-write handshakes.
//   desc_*    : descriptor offer/accept with dst, len, stride
//   src_*     : 32-bit input data stream (valid/ready)
//   dma_wr_*  : write beats into the buffer address map (valid/ready)
// Modports: master = the writer, slave = its environment.
interface dma_stream_writer_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int LEN_WIDTH    = 16,
  parameter int STRIDE_WIDTH = 16
) ();
  logic                    desc_valid_i;
  logic                    desc_ready_o;
  logic [ADDR_WIDTH-1:0]   desc_dst_addr_i;
  logic [LEN_WIDTH-1:0]    desc_len_i;
  logic [STRIDE_WIDTH-1:0] desc_stride_i;

  logic                    src_valid_i;
  logic [DATA_WIDTH-1:0]   src_data_i;
  logic                    src_ready_o;

  logic                    dma_wr_valid_o;
  logic [ADDR_WIDTH-1:0]   dma_wr_addr_o;
  logic [DATA_WIDTH-1:0]   dma_wr_data_o;
  logic                    dma_wr_ready_i;

  modport master (
    input  desc_valid_i, desc_dst_addr_i, desc_len_i, desc_stride_i,
    output desc_ready_o,
    input  src_valid_i, src_data_i,
    output src_ready_o,
    output dma_wr_valid_o, dma_wr_addr_o, dma_wr_data_o,
    input  dma_wr_ready_i
  );

  modport slave (
    output desc_valid_i, desc_dst_addr_i, desc_len_i, desc_stride_i,
    input  desc_ready_o,
    output src_valid_i, src_data_i,
    input  src_ready_o,
    input  dma_wr_valid_o, dma_wr_addr_o, dma_wr_data_o,
    output dma_wr_ready_i
  );
endinterface

// File: rtl/dma_sync_fifo.sv
// dma_sync_fifo: small synchronous FIFO, non-fall-through (a pushed entry
// becomes visible at the head on the following cycle).
//   clk_i, rst_ni : clock, synchronous active-low reset
//   flush_i       : synchronous empty
//   push_i/wdata_i, pop_i/rdata_o : write / read ports (ignored when full /
//                   empty respectively)
//   full_o, empty_o : status
module dma_sync_fifo
  import garuda_dma_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [PW:0]      r_count;
  logic             w_push, w_pop;

  assign full_o  = (r_count == (PW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign rdata_o = r_mem[r_rptr];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= wdata_i;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/dma_stream_writer.sv
// dma_stream_writer: accepts one descriptor (dst, len, stride) at a time,
// buffers the source stream in a small FIFO and issues address-incrementing
// DMA write beats.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   bus (master)    : descriptor, source stream and DMA write handshakes
//   abort_i         : abort the running transfer
//   busy_o          : FSM not idle
//   done_o          : one-cycle pulse at end of transfer (normal/abort/error)
//   err_o           : sticky error, cleared on next descriptor accept
//   words_left_o    : write beats not yet handshaken
// Optional: define DMA_REGION_CHECK_EN to reject descriptors whose first and
// last address do not fall inside one buffer region.
module dma_stream_writer
  import garuda_dma_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int LEN_WIDTH    = 16,
  parameter int STRIDE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  dma_stream_writer_if.master  bus,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [LEN_WIDTH-1:0] words_left_o
);
  dma_state_e              r_state;
  logic [ADDR_WIDTH-1:0]   r_cur_addr, r_wr_addr;
  logic [LEN_WIDTH-1:0]    r_beats_in, r_beats_out;
  logic [STRIDE_WIDTH-1:0] r_stride;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic                    r_wr_valid, r_desc_ready, r_done, r_err;

  logic                    w_desc_hs, w_src_ready, w_src_hs, w_wr_hs, w_last_hs;
  logic                    w_abort, w_load, w_flush, w_region_ok;
  logic                    w_fifo_full, w_fifo_empty;
  logic [DATA_WIDTH-1:0]   w_fifo_rdata;

`ifdef DMA_REGION_CHECK_EN
  // Wide enough that dst + (len-1)*stride cannot wrap; the extra top bit
  // flags overflow anyway so any wrap is treated as out of region.
  localparam int WW = ADDR_WIDTH + LEN_WIDTH + STRIDE_WIDTH + 1;
  logic [WW-1:0]          w_dst_wide, w_end_wide;
  logic [NUM_REGIONS-1:0] w_dst_hit, w_end_hit;

  assign w_dst_wide = WW'(bus.desc_dst_addr_i);
  assign w_end_wide = w_dst_wide
                    + WW'(bus.desc_len_i - LEN_WIDTH'(1)) * WW'(bus.desc_stride_i);

  always_comb begin
    w_dst_hit = '0;
    w_end_hit = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      w_dst_hit[r] = (w_dst_wide >= WW'(REGION_BASE[r])) && (w_dst_wide <= WW'(REGION_LIMIT[r]));
      w_end_hit[r] = (w_end_wide >= WW'(REGION_BASE[r])) && (w_end_wide <= WW'(REGION_LIMIT[r]));
    end
  end

  // Regions are disjoint, so a common set bit means both ends share one.
  assign w_region_ok = !w_end_wide[WW-1] && |(w_dst_hit & w_end_hit);
`else
  assign w_region_ok = 1'b1;
`endif

  assign w_desc_hs   = r_desc_ready && bus.desc_valid_i;
  // Never over-consume: stop once len beats have been taken from the source.
  assign w_src_ready = (r_state == S_RUN) && !abort_i && !w_fifo_full && (r_beats_in != '0);
  assign w_src_hs    = w_src_ready && bus.src_valid_i;
  assign w_wr_hs     = r_wr_valid && bus.dma_wr_ready_i;
  assign w_last_hs   = w_wr_hs && (r_beats_out == LEN_WIDTH'(1));
  // An abort landing on the final handshake is just a normal completion.
  assign w_abort     = (r_state == S_RUN) && abort_i && !w_last_hs;
  assign w_load      = (r_state == S_RUN) && !abort_i && !w_fifo_empty
                    && (!r_wr_valid || bus.dma_wr_ready_i);
  assign w_flush     = w_abort || (r_state == S_ABORT);

  dma_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (w_flush),
    .push_i  (w_src_hs),
    .wdata_i (bus.src_data_i),
    .pop_i   (w_load),
    .rdata_o (w_fifo_rdata),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= '0;
      r_wr_addr    <= '0;
      r_beats_in   <= '0;
      r_beats_out  <= '0;
      r_stride     <= '0;
      r_wr_data    <= '0;
      r_wr_valid   <= 1'b0;
      r_desc_ready <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_src_hs) r_beats_in  <= r_beats_in - 1'b1;
      if (w_wr_hs)  r_beats_out <= r_beats_out - 1'b1;

      // Output register holds addr/data stable until its handshake.
      if (w_load) begin
        r_wr_valid <= 1'b1;
        r_wr_addr  <= r_cur_addr;
        r_wr_data  <= w_fifo_rdata;
        r_cur_addr <= r_cur_addr + ADDR_WIDTH'(r_stride);
      end else if (w_wr_hs) begin
        r_wr_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_desc_ready <= !w_desc_hs;
          if (w_desc_hs) begin
            r_cur_addr  <= bus.desc_dst_addr_i;
            r_beats_in  <= bus.desc_len_i;
            r_beats_out <= bus.desc_len_i;
            r_stride    <= bus.desc_stride_i;
            if (bus.desc_len_i == '0 || !w_region_ok) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_err   <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (w_last_hs) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (w_abort) begin
            r_state <= S_ABORT;
          end
        end
        S_ABORT: begin
          // Let the presented beat finish, then report.
          if (!r_wr_valid || bus.dma_wr_ready_i) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          r_state      <= S_IDLE;
          r_desc_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.desc_ready_o   = r_desc_ready;
  assign bus.src_ready_o    = w_src_ready;
  assign bus.dma_wr_valid_o = r_wr_valid;
  assign bus.dma_wr_addr_o  = r_wr_addr;
  assign bus.dma_wr_data_o  = r_wr_data;
  assign busy_o             = (r_state != S_IDLE);
  assign done_o             = r_done;
  assign err_o              = r_err;
  assign words_left_o       = r_beats_out;
endmodule

// File: tb/tb_dma_stream_writer.sv
module tb_dma_stream_writer;
  import garuda_dma_pkg::*;

  localparam int DW = 32, AW = 32, LW = 16, SW = 16, FD = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          abort_i = 1'b0;
  logic          busy_o, done_o, err_o;
  logic [LW-1:0] words_left_o;

  dma_stream_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .STRIDE_WIDTH(SW)) bus ();

  dma_stream_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
                      .STRIDE_WIDTH(SW), .FIFO_DEPTH(FD)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .bus          (bus),
    .abort_i      (abort_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .words_left_o (words_left_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  int            checks = 0, errors = 0, cyc = 0;
  beat_t         exp_q[$];
  logic [DW-1:0] src_q[$];
  bit            src_kill = 0, src_fast = 0;
  int            ready_mode = 1;   // 0 low, 1 high, 2 random, 3 toggle
  int            beats_seen = 0, done_cnt = 0;
  int            hs_cyc[$];
  logic [LW-1:0] exp_left = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int region_of(input longint unsigned a);
    if (a <= 64'h1FFFF) return 0;
    if (a >= 64'h20000 && a <= 64'h2FFFF) return 1;
    if (a >= 64'h30000 && a <= 64'h3FFFF) return 2;
    if (a >= 64'h40000 && a <= 64'h47FFF) return 3;
    return -1;
  endfunction

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Downstream ready generator.
  initial begin
    bus.dma_wr_ready_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      case (ready_mode)
        0:       bus.dma_wr_ready_i = 1'b0;
        1:       bus.dma_wr_ready_i = 1'b1;
        2:       bus.dma_wr_ready_i = 1'($urandom_range(0, 1));
        default: bus.dma_wr_ready_i = ~bus.dma_wr_ready_i;
      endcase
    end
  end

  // Source stream driver: holds a beat until accepted.
  initial begin
    bit hs;
    bus.src_valid_i = 1'b0;
    bus.src_data_i  = '0;
    forever begin
      @(negedge clk_i);
      hs = bus.src_valid_i && bus.src_ready_o;
      @(posedge clk_i); #1;
      if (src_kill) begin
        src_q.delete();
        bus.src_valid_i = 1'b0;
      end else begin
        if (hs) void'(src_q.pop_front());
        if (!(bus.src_valid_i && !hs)) begin
          if (src_q.size() > 0 && (src_fast || $urandom_range(0, 3) != 0)) begin
            bus.src_valid_i = 1'b1;
            bus.src_data_i  = src_q[0];
          end else begin
            bus.src_valid_i = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every write handshake.
  initial begin
    logic          pv, pr;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    beat_t         e;
    pv = 0; pr = 0; pa = '0; pd = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        pv = 0;
      end else begin
        if (pv && !pr) begin
          chk("wr_hold_valid", 64'(bus.dma_wr_valid_o), 64'(1));
          chk("wr_hold_addr", 64'(bus.dma_wr_addr_o), 64'(pa));
          chk("wr_hold_data", 64'(bus.dma_wr_data_o), 64'(pd));
        end
        if (done_o) done_cnt++;
        if (bus.dma_wr_valid_o && bus.dma_wr_ready_i) begin
          beats_seen++;
          hs_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got addr %0h data %0h expected no beat",
                     bus.dma_wr_addr_o, bus.dma_wr_data_o);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(bus.dma_wr_addr_o), 64'(e.addr));
            chk("wr_data", 64'(bus.dma_wr_data_o), 64'(e.data));
          end
          chk("words_left", 64'(words_left_o), 64'(exp_left));
          exp_left = exp_left - 1'b1;
        end
        pv = bus.dma_wr_valid_o;
        pr = bus.dma_wr_ready_i;
        pa = bus.dma_wr_addr_o;
        pd = bus.dma_wr_data_o;
      end
    end
  end

  task automatic offer_desc(input dma_desc_t d, output bit ok);
    ok = 0;
    @(posedge clk_i); #1;
    bus.desc_valid_i    = 1'b1;
    bus.desc_dst_addr_i = d.dst;
    bus.desc_len_i      = d.len;
    bus.desc_stride_i   = d.stride;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (bus.desc_ready_o) begin ok = 1; break; end
    end
    @(posedge clk_i); #1;
    bus.desc_valid_i = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL desc_accept: got no desc_ready_o expected accept within 50 cycles");
    end
  endtask

  // Runs one descriptor end to end against the reference beat list.
  task automatic run_desc(input dma_desc_t d, input int mode, input bit seq,
                          input logic [DW-1:0] dbase, input bit do_abort);
    bit            exp_err, ok;
    int            d0;
    logic [DW-1:0] data;
    longint unsigned last;
    exp_err = (d.len == 0);
`ifdef DMA_REGION_CHECK_EN
    if (!exp_err) begin
      last = longint'(d.dst) + longint'(d.len - 1) * longint'(d.stride);
      if (region_of(longint'(d.dst)) < 0 || region_of(longint'(d.dst)) != region_of(last))
        exp_err = 1;
    end
`else
    last = 0;
`endif
    beats_seen = 0;
    hs_cyc.delete();
    exp_left   = d.len;
    ready_mode = mode;
    d0 = done_cnt;
    if (!exp_err) begin
      for (int i = 0; i < int'(d.len); i++) begin
        data = seq ? dbase + DW'(i) : $urandom;
        src_q.push_back(data);
        exp_q.push_back('{addr: d.dst + AW'(i) * AW'(d.stride), data: data});
      end
    end
    offer_desc(d, ok);
    @(negedge clk_i);
    chk("err_after_accept", 64'(err_o), 64'(exp_err));
    if (exp_err) chk("done_after_err_accept", 64'(done_o), 64'(1));
    if (do_abort) begin
      for (int i = 0; i < 2000 && beats_seen < 3; i++) @(negedge clk_i);
      @(posedge clk_i); #1;
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0;
    end
    for (int i = 0; i < 2000 && done_cnt == d0; i++) @(negedge clk_i);
    if (done_cnt == d0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done_o expected a pulse within 2000 cycles");
    end
    chk("err_at_done", 64'(err_o), 64'(exp_err || do_abort));
    if (do_abort) begin
      chk("abort_partial", 64'(beats_seen >= 3 && beats_seen < int'(d.len)), 64'(1));
      exp_q.delete();
      src_kill = 1;
      repeat (2) @(negedge clk_i);
      src_kill = 0;
    end else begin
      chk("beat_count", 64'(beats_seen), exp_err ? 64'(0) : 64'(d.len));
      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    end
    repeat (3) @(negedge clk_i);
    chk("done_once", 64'(done_cnt - d0), 64'(1));
    chk("idle_after", 64'(busy_o), 64'(0));
  endtask

  initial begin
    dma_desc_t d;
    bit        ok;
    bus.desc_valid_i = 1'b0;
    bus.desc_dst_addr_i = '0;
    bus.desc_len_i = '0;
    bus.desc_stride_i = '0;

    // Reset state.
    repeat (3) @(negedge clk_i);
    chk("rst_outs", 64'({bus.desc_ready_o, bus.src_ready_o, bus.dma_wr_valid_o,
                         busy_o, done_o, err_o}), 64'(0));
    chk("rst_words_left", 64'(words_left_o), 64'(0));
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Streaming at full rate.
    src_fast = 1;
    d = '{dst: 32'h20000, len: 16'd4, stride: 16'd1};
    run_desc(d, 1, 1, 32'hA0, 0);
    chk("b2b_cycles", (hs_cyc.size() == 4) ? 64'(hs_cyc[3] - hs_cyc[0]) : 64'hFFFF, 64'(3));
    src_fast = 0;

    // Stride 4 with stalls.
    d = '{dst: 32'h40000, len: 16'd3, stride: 16'd4};
    run_desc(d, 3, 0, '0, 0);

    // Illegal zero length.
    d = '{dst: 32'h20000, len: 16'd0, stride: 16'd1};
    run_desc(d, 1, 0, '0, 0);

    // Abort mid-transfer, then a clean descriptor clears err_o.
    src_fast = 1;
    d = '{dst: 32'h20100, len: 16'd8, stride: 16'd1};
    run_desc(d, 1, 0, '0, 1);
    src_fast = 0;
    d = '{dst: 32'h30000, len: 16'd5, stride: 16'd2};
    run_desc(d, 2, 0, '0, 0);

    // Reset mid-transfer with a beat presented.
    ready_mode = 0;
    exp_left = 16'd6;
    for (int i = 0; i < FD + 1; i++) src_q.push_back($urandom);
    d = '{dst: 32'h30000, len: 16'd6, stride: 16'd1};
    offer_desc(d, ok);
    for (int i = 0; i < 200 && (src_q.size() != 0 || bus.src_valid_i); i++) @(negedge clk_i);
    @(negedge clk_i);
    chk("pre_rst_valid", 64'(bus.dma_wr_valid_o), 64'(1));
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("midrst_outs", 64'({bus.desc_ready_o, bus.src_ready_o, bus.dma_wr_valid_o,
                            busy_o, done_o, err_o}), 64'(0));
    chk("midrst_words", 64'(words_left_o), 64'(0));
    chk("midrst_addr", 64'(bus.dma_wr_addr_o), 64'(0));
    exp_q.delete();
    d = '{dst: 32'h40010, len: 16'd6, stride: 16'd3};
    run_desc(d, 2, 0, '0, 0);

    // Region boundary crossing.
    d = '{dst: 32'h1FFFE, len: 16'd4, stride: 16'd1};
    run_desc(d, 1, 0, '0, 0);

    // Randomized legal descriptors.
    for (int n = 0; n < 8; n++) begin
      d.dst    = 32'h20000 + 32'($urandom_range(0, 2)) * 32'h10000 + 32'($urandom_range(0, 255));
      d.len    = 16'($urandom_range(1, 12));
      d.stride = 16'($urandom_range(0, 16));
      run_desc(d, 2, 0, '0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1);
  end
endmodule
